rdac_serial_loader: RTL

Serial write engine for the RDAC chip, sitting directly downstream of the chip-clock divider. It takes a parallel word and a start strobe, releases the divider's hold input, and watches the divided chip clock (SC_clk) edges in the 100 MHz domain. It shifts the word out MSB-first under an active-low chip select, then stops the divider and returns idle with a one-cycle done pulse.

---
 rtl/rdac_serial_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rdac_serial_loader.sv
// rdac_serial_loader: serial write engine for the RDAC chip.
// Releases the chip-clock divider, follows its output edges in the clki domain
// and shifts a parallel word out MSB-first under an active-low chip select.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; divider held, cs_n high
//   S_SHIFT | divider running; count rises, shift on falls
//   S_HOLD  | divider stopped; cs_n held low HOLD_CYC cycles after last bit
//   S_GAP   | cs_n high, still busy for HOLD_CYC cycles (min inter-frame gap)
`timescale 1ns/1ps
module rdac_serial_loader #(
    parameter int DATA_W   = 16,
    parameter int HOLD_CYC = 4
) (
    input  logic              i_clki,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_sc_clk,
    output logic              o_div_enb,
    output logic              o_cs_n,
    output logic              o_sdo,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYC - 1);

    logic [1:0]        r_state;
    logic              r_sc_d;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [HC_W-1:0]   r_hold_cnt;
    logic              r_div_enb;
    logic              r_cs_n;
    logic              r_busy;
    logic              r_done;

    logic w_rise;
    logic w_fall;
    logic w_drive_sdo;

    assign w_rise      = i_sc_clk & ~r_sc_d;
    assign w_fall      = ~i_sc_clk & r_sc_d;
    // The MSB is only presented while a frame owns the line; otherwise sdo rests low.
    assign w_drive_sdo = (r_state == S_SHIFT) || (r_state == S_HOLD);

    assign o_div_enb = r_div_enb;
    assign o_cs_n    = r_cs_n;
    assign o_sdo     = w_drive_sdo & r_shreg[DATA_W-1];
    assign o_busy    = r_busy;
    assign o_done    = r_done;

    // Delayed copy of the divided clock for edge detection.
    always_ff @(posedge i_clki or posedge i_rst) begin
        if (i_rst) begin
            r_sc_d <= 1'b0;
        end else begin
            r_sc_d <= i_sc_clk;
        end
    end

    // Frame sequencer: load, shift on divider edges, CS hold, inter-frame gap.
    always_ff @(posedge i_clki or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
            r_div_enb  <= 1'b1;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shreg   <= i_din;
                        r_bit_cnt <= '0;
                        r_cs_n    <= 1'b0;
                        r_div_enb <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Saturate so a stray extra rise cannot wrap the count.
                    if (w_rise && (r_bit_cnt < BIT_LAST)) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                    if (w_fall) begin
                        if (r_bit_cnt < BIT_LAST) begin
                            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                        end else begin
                            // Last bit already sampled by the device: stop the divider.
                            r_div_enb  <= 1'b1;
                            r_hold_cnt <= HOLD_LOAD;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_cs_n     <= 1'b1;
                        r_done     <= 1'b1;
                        r_hold_cnt <= HOLD_LOAD;
                        r_state    <= S_GAP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HC_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_hold_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HC_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
